// File: rtl/mem_block_mover_pkg.sv
// mem_block_mover_pkg: FSM encoding, status word layout and reserved cell addresses
// shared by the block mover and its users.
package mem_block_mover_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, BUSY, READ, CAPT, WRITE, DONE, ERR} state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_CNT_LSB = 16;
    localparam int CFG_ADDR     = 0;
    localparam int STAT_ADDR    = 1;

    function automatic logic [31:0] status_word(input logic [15:0] moved, input logic busy,
                                                input logic done, input logic err);
        logic [31:0] w;
        w = '0;
        w[STAT_CNT_LSB +: 16] = moved;
        w[STAT_BUSY] = busy;
        w[STAT_DONE] = done;
        w[STAT_ERR]  = err;
        return w;
    endfunction
endpackage

// File: rtl/mem_block_mover.sv
// mem_block_mover: copies in_count wide blocks from in_src to in_dst through the block
// memory's single-cycle read/write port, reporting progress via the status cell.
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int size       = 1024,
    parameter int blocks     = 4,
    parameter int log_size   = 10,
    parameter int cell_width = 32,
    parameter int width      = blocks * cell_width
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic                  in_start,
    input  logic [log_size-1:0]   in_src,
    input  logic [log_size-1:0]   in_dst,
    input  logic [log_size-1:0]   in_count,
    input  logic [width-1:0]      in_mem_data,
    output logic [log_size-1:0]   out_mem_address,
    output logic [width-1:0]      out_mem_data,
    output logic                  out_mem_read_en,
    output logic                  out_mem_write_en,
    output logic [cell_width-1:0] out_mem_status,
    output logic                  out_mem_write_status_en,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_error
);
    localparam int CW = log_size + $clog2(blocks) + 1;

    state_t              state;
    logic [log_size-1:0] src_cur, dst_cur, count, moved, moved_nx, step;
    logic [width-1:0]    buffer;
    logic [CW-1:0]       span, src_end, dst_end;
    logic                range_err;

    // Range checks run one bit wider than any reachable end address so nothing wraps.
    assign span      = CW'(count) * CW'(blocks);
    assign src_end   = CW'(src_cur) + span;
    assign dst_end   = CW'(dst_cur) + span;
    assign range_err = (src_end > CW'(size)) || (dst_end > CW'(size)) ||
                       (count != '0 && dst_cur <= log_size'(STAT_ADDR));
    assign moved_nx  = moved + 1'b1;
    assign step      = log_size'(blocks);
    assign out_mem_data = buffer;

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state                   <= IDLE;
            src_cur                 <= '0;
            dst_cur                 <= '0;
            count                   <= '0;
            moved                   <= '0;
            buffer                  <= '0;
            out_mem_address         <= '0;
            out_mem_read_en         <= 1'b0;
            out_mem_write_en        <= 1'b0;
            out_mem_status          <= '0;
            out_mem_write_status_en <= 1'b0;
            out_busy                <= 1'b0;
            out_done                <= 1'b0;
            out_error               <= 1'b0;
        end else begin
            out_mem_read_en         <= 1'b0;
            out_mem_write_en        <= 1'b0;
            out_mem_write_status_en <= 1'b0;
            out_done                <= 1'b0;
            case (state)
                IDLE: if (in_start) begin
                    state     <= CHECK;
                    src_cur   <= in_src;
                    dst_cur   <= in_dst;
                    count     <= in_count;
                    moved     <= '0;
                    out_error <= 1'b0;
                    out_busy  <= 1'b1;
                end
                CHECK: begin
                    state                   <= range_err ? ERR : BUSY;
                    out_mem_write_status_en <= 1'b1;
                    out_mem_status          <= cell_width'(range_err ? status_word('0, 1'b0, 1'b1, 1'b1)
                                                                     : status_word('0, 1'b1, 1'b0, 1'b0));
                    out_error               <= range_err;
                    out_done                <= range_err;
                end
                BUSY: if (count == '0) begin
                    // Zero-length moves still pass through BUSY so done lands two cycles after start.
                    state                   <= DONE;
                    out_mem_write_status_en <= 1'b1;
                    out_mem_status          <= cell_width'(status_word('0, 1'b0, 1'b1, 1'b0));
                    out_done                <= 1'b1;
                end else begin
                    state           <= READ;
                    out_mem_read_en <= 1'b1;
                    out_mem_address <= src_cur;
                end
                READ: state <= CAPT;
                CAPT: begin
                    state            <= WRITE;
                    buffer           <= in_mem_data;
                    out_mem_write_en <= 1'b1;
                    out_mem_address  <= dst_cur;
                end
                WRITE: begin
                    moved   <= moved_nx;
                    src_cur <= src_cur + step;
                    dst_cur <= dst_cur + step;
                    if (moved_nx < count) begin
                        state           <= READ;
                        out_mem_read_en <= 1'b1;
                        out_mem_address <= src_cur + step;
                    end else begin
                        state                   <= DONE;
                        out_mem_write_status_en <= 1'b1;
                        out_mem_status          <= cell_width'(status_word(16'(moved_nx), 1'b0, 1'b1, 1'b0));
                        out_done                <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    state    <= IDLE;
                    out_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
